// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register between two pipeline stages.
// With SKID_EN=1 a second (skid) entry absorbs the one extra beat that can
// arrive while in_ready is registered, so in_ready never depends on out_ready
// combinationally. With SKID_EN=0 the stage is a single register and in_ready
// is derived combinationally from the downstream handshake.
// out_valid, out_data and occupancy always come straight from flops; an
// empty or flushed stage drives NOP_PAYLOAD on out_data.
module pipe_stage_reg #(
    parameter int unsigned          DATA_W      = 96,
    parameter int unsigned          SKID_EN     = 1,
    parameter logic [DATA_W-1:0]    NOP_PAYLOAD = {DATA_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic                out_valid_r;
    logic                in_ready_r;
    logic [1:0]          occupancy_r;

    logic                in_xfer_s;
    logic                out_xfer_s;

    // Handshake decode: a beat moves only when both sides agree this cycle.
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid_r && out_ready;

    // Skid mode presents the registered ready; single-register mode lets a
    // consuming downstream make room in the same cycle.
    assign in_ready  = (SKID_EN != 0) ? in_ready_r : (!out_valid_r || out_ready);
    assign out_valid = out_valid_r;
    assign out_data  = main_data_r;
    assign occupancy = occupancy_r;

    // Stage state machine: reset and flush both drop every held entry,
    // reset wins when both are asserted (the result is the same).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r     <= ST_EMPTY;
            main_data_r <= NOP_PAYLOAD;
            skid_data_r <= NOP_PAYLOAD;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_r     <= ST_FULL;
                        main_data_r <= in_data;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_xfer_s && out_xfer_s) begin
                        // Streaming: replace the departing entry in place.
                        main_data_r <= in_data;
                    end else if (in_xfer_s) begin
                        // Downstream stalled: park the new beat behind main
                        // so it leaves second and order is preserved.
                        if (SKID_EN != 0) begin
                            state_r     <= ST_SKID;
                            skid_data_r <= in_data;
                            in_ready_r  <= 1'b0;
                            occupancy_r <= 2'd2;
                        end else begin
                            state_r     <= ST_FULL;
                        end
                    end else if (out_xfer_s) begin
                        state_r     <= ST_EMPTY;
                        main_data_r <= NOP_PAYLOAD;
                        out_valid_r <= 1'b0;
                        occupancy_r <= 2'd0;
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_xfer_s) begin
                        state_r     <= ST_FULL;
                        main_data_r <= skid_data_r;
                        skid_data_r <= NOP_PAYLOAD;
                        in_ready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r     <= ST_SKID;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    main_data_r <= NOP_PAYLOAD;
                    skid_data_r <= NOP_PAYLOAD;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    occupancy_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random bench for pipe_stage_reg. Instance a uses the skid
// buffer, instance b the single-register variant; both share clk and rst.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int checks;
    int errors;

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(1), .NOP_PAYLOAD(NOP)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .SKID_EN(0), .NOP_PAYLOAD(NOP)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every output of instance a against expectations.
    task automatic check_a(input string name, input logic ev, input logic [31:0] ed,
                           input logic [1:0] eo, input logic er);
        checks++;
        if (a_out_valid !== ev || a_out_data !== ed || a_occ !== eo || a_in_ready !== er) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h occ=%0d ready=%b, want valid=%b data=%h occ=%0d ready=%b",
                     name, a_out_valid, a_out_data, a_occ, a_in_ready, ev, ed, eo, er);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'h0000_0077; a_out_ready = 1'b0;
        step();
        check_a("reset_a", 1'b0, NOP, 2'd0, 1'b1);
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== NOP || b_occ !== 2'd0) begin
            errors++;
            $display("FAIL reset_b: got valid=%b data=%h occ=%0d, want 0 %h 0",
                     b_out_valid, b_out_data, b_occ, NOP);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        step();
        check_a("reset_idle_a", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_streaming();
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_data = 32'(i);
            step();
            check_a("stream", 1'b1, 32'(i), 2'd1, 1'b1);
        end
        a_in_valid = 1'b0;
        step();
        check_a("stream_drain", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_stall_fill();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h0000_000A;
        step();
        check_a("fill_1", 1'b1, 32'h0000_000A, 2'd1, 1'b1);
        a_in_data = 32'h0000_000B;
        step();
        check_a("fill_2", 1'b1, 32'h0000_000A, 2'd2, 1'b0);
        // in_valid held high while full: must be ignored, payload stable
        a_in_data = 32'h0000_000C;
        step();
        check_a("fill_hold", 1'b1, 32'h0000_000A, 2'd2, 1'b0);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        check_a("drain_1", 1'b1, 32'h0000_000B, 2'd1, 1'b1);
        step();
        check_a("drain_2", 1'b0, NOP, 2'd0, 1'b1);
    endtask

    task automatic test_flush();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h0000_0011;
        step();
        a_in_data = 32'h0000_0022;
        step();
        check_a("flush_pre", 1'b1, 32'h0000_0011, 2'd2, 1'b0);
        a_in_data = 32'h0000_0033; a_out_ready = 1'b1; a_flush = 1'b1;
        step();
        check_a("flush_now", 1'b0, NOP, 2'd0, 1'b1);
        a_flush = 1'b0; a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("flush_after", 1'b0, NOP, 2'd0, 1'b1);
        end
        // flush from FULL with a simultaneous accept also drops the offer
        a_in_valid = 1'b1; a_in_data = 32'h0000_0044; a_out_ready = 1'b0;
        step();
        a_in_data = 32'h0000_0045; a_flush = 1'b1;
        step();
        check_a("flush_full", 1'b0, NOP, 2'd0, 1'b1);
        a_flush = 1'b0; a_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h0000_0066;
        step();
        a_in_data = 32'h0000_0067;
        step();
        check_a("rst_pre", 1'b1, 32'h0000_0066, 2'd2, 1'b0);
        rst = 1'b1; a_flush = 1'b1; a_out_ready = 1'b1; a_in_data = 32'h0000_0099;
        step();
        check_a("rst_mid", 1'b0, NOP, 2'd0, 1'b1);
        rst = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0; a_in_data = 32'h0000_0055;
        step();
        check_a("rst_first", 1'b1, 32'h0000_0055, 2'd1, 1'b1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        check_a("rst_drain", 1'b0, NOP, 2'd0, 1'b1);
        a_out_ready = 1'b0;
    endtask

    task automatic test_no_skid();
        b_in_valid = 1'b1; b_in_data = 32'h0000_0003; b_out_ready = 1'b0;
        step();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h0000_0003 || b_occ !== 2'd1 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL noskid_stall: got valid=%b data=%h occ=%0d ready=%b, want 1 00000003 1 0",
                     b_out_valid, b_out_data, b_occ, b_in_ready);
        end
        b_out_ready = 1'b1; b_in_data = 32'h0000_0007;
        #1;
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_comb_ready: got %b want 1", b_in_ready);
        end
        step();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h0000_0007 || b_occ !== 2'd1) begin
            errors++;
            $display("FAIL noskid_pass: got valid=%b data=%h occ=%0d, want 1 00000007 1",
                     b_out_valid, b_out_data, b_occ);
        end
        b_in_valid = 1'b0;
        step();
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== NOP || b_occ !== 2'd0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_drain: got valid=%b data=%h occ=%0d ready=%b, want 0 %h 0 1",
                     b_out_valid, b_out_data, b_occ, b_in_ready, NOP);
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] seq;
        logic ia, oa, ib, ob, fa, fb;
        logic [31:0] ea, eb;
        seq = 32'h1000_0000;
        for (int c = 0; c < 10000; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 127) == 0);
            a_in_data   = a_in_valid ? seq : $urandom;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 127) == 0);
            b_in_data   = b_in_valid ? (seq ^ 32'h8000_0000) : $urandom;
            seq = seq + 32'd1;
            #1;
            ea = (qa.size() > 0) ? qa[0] : NOP;
            eb = (qb.size() > 0) ? qb[0] : NOP;
            checks++;
            if (a_out_valid !== (qa.size() > 0) || a_out_data !== ea ||
                a_occ !== 2'(qa.size()) || a_in_ready !== (qa.size() < 2)) begin
                errors++;
                $display("FAIL rand_a cycle %0d: got valid=%b data=%h occ=%0d ready=%b, want data=%h occ=%0d",
                         c, a_out_valid, a_out_data, a_occ, a_in_ready, ea, qa.size());
            end
            checks++;
            if (b_out_valid !== (qb.size() > 0) || b_out_data !== eb ||
                b_occ !== 2'(qb.size()) || b_in_ready !== (qb.size() == 0 || b_out_ready)) begin
                errors++;
                $display("FAIL rand_b cycle %0d: got valid=%b data=%h occ=%0d ready=%b, want data=%h occ=%0d",
                         c, b_out_valid, b_out_data, b_occ, b_in_ready, eb, qb.size());
            end
            ia = a_in_valid && a_in_ready;  oa = a_out_valid && a_out_ready;  fa = a_flush;
            ib = b_in_valid && b_in_ready;  ob = b_out_valid && b_out_ready;  fb = b_flush;
            @(posedge clk);
            #1;
            if (fa) qa.delete();
            else begin
                if (oa && qa.size() > 0) void'(qa.pop_front());
                if (ia) qa.push_back(a_in_data);
            end
            if (fb) qb.delete();
            else begin
                if (ob && qb.size() > 0) void'(qb.pop_front());
                if (ib) qb.push_back(b_in_data);
            end
        end
        a_in_valid = 1'b0; a_flush = 1'b0; b_in_valid = 1'b0; b_flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = 32'd0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = 32'd0; b_out_ready = 1'b0;
        #1;
        test_reset();
        test_streaming();
        test_stall_fill();
        test_flush();
        test_reset_mid_stall();
        test_no_skid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
